// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // The same encodings as plain constants for the logic-typed state register.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // True when a byte PC is word aligned.
    function automatic logic is_aligned(input logic [1:0] pc_low);
        return (pc_low == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, inst} pairs between the memory response and decode.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [63:0] pop_data,
    output logic [1:0]  count
);

    logic [63:0] entry_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  cnt;
    logic        do_push;
    logic        do_pop;

    // Guard against overflow/underflow so the pointers can never desynchronise.
    always_comb begin
        do_push = push && (cnt != 2'd2);
        do_pop  = pop && (cnt != 2'd0);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            cnt        <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign pop_data = entry_q[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the synchronous
// instruction memory and hands {pc, inst} pairs to decode.
//
// Output handshake: an entry transfers in any cycle where out_valid and
// out_ready are both 1. While out_valid is 1 and the entry has not
// transferred, out_pc and out_inst hold steady; out_valid never depends on
// out_ready. Only a redirect (flush) removes an entry without a transfer.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_dir,
    input  logic [31:0]       mem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fault,
    output logic [1:0]        dbg_state
);

    localparam int         LOW_W     = ADDR_W + 2;
    localparam logic [2:0] OCC_LIMIT = 3'(FIFO_DEPTH);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        inflight;
    logic        inflight_epoch;
    logic [31:0] inflight_pc;
    logic        epoch;
    logic        fault_q;

    logic [1:0]  fifo_count;
    logic [63:0] fifo_head;
    logic        pop;
    logic        push;
    logic [2:0]  occ;
    logic        issue;
    logic        redirect_ok;
    logic        redirect_bad;

    // Handshake, occupancy and issue decision.
    always_comb begin
        redirect_ok  = redirect_valid && is_aligned(redirect_pc[1:0]);
        redirect_bad = redirect_valid && !is_aligned(redirect_pc[1:0]);
        out_valid    = (fifo_count != 2'd0) && (state != S_FAULT);
        pop          = out_valid && out_ready;
        // Slots already claimed once this cycle's transfer has left.
        occ          = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        issue        = (state == S_RUN) && (occ < OCC_LIMIT);
        // A response counts only if it belongs to the current epoch and no
        // redirect is flushing the buffer on this edge.
        push         = inflight && (inflight_epoch == epoch) && !redirect_valid;
        // Sequential PC wraps inside the memory's byte range, upper bits kept.
        pc_inc       = {pc[31:LOW_W], pc[LOW_W-1:0] + LOW_W'(PC_STEP)};
    end

    // Next-state logic; redirects take priority over the fetch_en transitions.
    always_comb begin
        state_nxt = state;
        if (redirect_bad) begin
            state_nxt = S_FAULT;
        end else if (redirect_ok) begin
            state_nxt = fetch_en ? S_RUN : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (fetch_en)  state_nxt = S_RUN;
                S_RUN:   if (!fetch_en) state_nxt = S_IDLE;
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM, PC, in-flight tracking, epoch and fault pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            epoch          <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state          <= state_nxt;
            fault_q        <= redirect_bad;
            inflight       <= issue;
            // The epoch captured here is the pre-redirect one, so a read
            // issued in a redirect cycle is recognised as stale on return.
            inflight_epoch <= epoch;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect_valid) begin
                epoch <= ~epoch;
            end
            if (redirect_ok) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc_inc;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({inflight_pc, mem_inst}),
        .pop       (pop),
        .flush     (redirect_valid),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign mem_en    = issue;
    assign mem_dir   = issue ? pc[LOW_W-1:2] : '0;
    assign out_pc    = out_valid ? fifo_head[63:32] : 32'd0;
    assign out_inst  = out_valid ? fifo_head[31:0]  : 32'd0;
    assign fault     = fault_q;
    assign dbg_state = state;

endmodule
